// File: rtl/sfx_sequencer_pkg.sv
// Shared types and constants for the sound-effect sequencer: FSM states, ROM word layout,
// and the word packing helper used to build the effect ROM.
package sfx_sequencer_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 250000;
  localparam int unsigned NumFx            = 4;
  localparam int unsigned IdW              = 2;
  localparam int unsigned StepW            = 3;
  localparam int unsigned RomAw            = IdW + StepW;
  localparam int unsigned RomDepth         = 32;

  // Field widths
  localparam int unsigned DurW    = 8;
  localparam int unsigned LfoW    = 10;
  localparam int unsigned NoiseW  = 12;
  localparam int unsigned VcoW    = 12;
  localparam int unsigned ShiftW  = 3;
  localparam int unsigned MixW    = 4;

  // Field offsets, LSB first; the word width follows from the field widths
  localparam int unsigned LastOff     = 0;
  localparam int unsigned MixOff      = LastOff + 1;
  localparam int unsigned ShiftOff    = MixOff + MixW;
  localparam int unsigned NoiseSelOff = ShiftOff + ShiftW;
  localparam int unsigned Vco2SelOff  = NoiseSelOff + 1;
  localparam int unsigned Vco1SelOff  = Vco2SelOff + 1;
  localparam int unsigned Vco2Off     = Vco1SelOff + 1;
  localparam int unsigned Vco1Off     = Vco2Off + VcoW;
  localparam int unsigned NoiseOff    = Vco1Off + VcoW;
  localparam int unsigned LfoOff      = NoiseOff + NoiseW;
  localparam int unsigned DurOff      = LfoOff + LfoW;
  localparam int unsigned RomW        = DurOff + DurW;

  // dur = 0 encodes the longest step, so the duration counter needs one extra bit
  localparam int unsigned DurCntW = DurW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StApply,
    StPlay
  } state_e;

  // Member order matches the offsets above (first member is the MSB)
  typedef struct packed {
    logic [DurW-1:0]   dur;
    logic [LfoW-1:0]   lfo;
    logic [NoiseW-1:0] noise;
    logic [VcoW-1:0]   vco1;
    logic [VcoW-1:0]   vco2;
    logic              vco1_sel;
    logic              vco2_sel;
    logic              noise_sel;
    logic [ShiftW-1:0] lfo_shift;
    logic [MixW-1:0]   mixer;
    logic              last;
  } sfx_word_t;

  function automatic logic [RomW-1:0] sfx_pack(
    input logic [DurW-1:0]   dur,
    input logic [LfoW-1:0]   lfo,
    input logic [NoiseW-1:0] noise,
    input logic [VcoW-1:0]   vco1,
    input logic [VcoW-1:0]   vco2,
    input logic              vco1_sel,
    input logic              vco2_sel,
    input logic              noise_sel,
    input logic [ShiftW-1:0] lfo_shift,
    input logic [MixW-1:0]   mixer,
    input logic              last
  );
    logic [RomW-1:0] w;
    w                       = '0;
    w[DurOff +: DurW]       = dur;
    w[LfoOff +: LfoW]       = lfo;
    w[NoiseOff +: NoiseW]   = noise;
    w[Vco1Off +: VcoW]      = vco1;
    w[Vco2Off +: VcoW]      = vco2;
    w[Vco1SelOff]           = vco1_sel;
    w[Vco2SelOff]           = vco2_sel;
    w[NoiseSelOff]          = noise_sel;
    w[ShiftOff +: ShiftW]   = lfo_shift;
    w[MixOff +: MixW]       = mixer;
    w[LastOff]              = last;
    return w;
  endfunction

endpackage

// File: rtl/sfx_sequencer_rom.sv
// Effect ROM: 4 effects x 8 steps, addressed by {effect id, step}, one-cycle registered read.
module sfx_rom
  import sfx_sequencer_pkg::*;
(
  input  logic             clk_i,
  input  logic [RomAw-1:0] addr_i,
  output logic [RomW-1:0]  data_o
);

  logic [RomW-1:0] mem [RomDepth];

  initial begin
    for (int i = 0; i < RomDepth; i++) mem[RomAw'(i)] = '0;
    // Effect 0: single step
    mem[RomAw'(0)]  = sfx_pack(8'd3, 10'h011, 12'h101, 12'h201, 12'h301,
                               1'b1, 1'b0, 1'b1, 3'd1, 4'h9, 1'b1);
    // Effect 1: two steps
    mem[RomAw'(8)]  = sfx_pack(8'd2, 10'h021, 12'h111, 12'h211, 12'h311,
                               1'b0, 1'b1, 1'b0, 3'd2, 4'hA, 1'b0);
    mem[RomAw'(9)]  = sfx_pack(8'd1, 10'h022, 12'h112, 12'h212, 12'h312,
                               1'b1, 1'b1, 1'b0, 3'd3, 4'hB, 1'b1);
    // Effect 2: two steps
    mem[RomAw'(16)] = sfx_pack(8'd5, 10'h031, 12'h121, 12'h221, 12'h321,
                               1'b0, 1'b0, 1'b1, 3'd4, 4'hC, 1'b0);
    mem[RomAw'(17)] = sfx_pack(8'd2, 10'h032, 12'h122, 12'h222, 12'h322,
                               1'b1, 1'b0, 1'b0, 3'd5, 4'hD, 1'b1);
    // Effect 3: eight steps, never flagged last; step 0 runs the maximum 256 ticks
    for (int k = 0; k < 8; k++) begin
      mem[RomAw'(24 + k)] = sfx_pack((k == 0) ? 8'd0 : 8'd1,
                                     10'h041 + 10'(k), 12'h131 + 12'(k),
                                     12'h231 + 12'(k), 12'h331 + 12'(k),
                                     1'(k), 1'(k >> 1), 1'(k >> 2),
                                     3'(k), 4'(k + 1), 1'b0);
    end
  end

  always_ff @(posedge clk_i) begin
    data_o <= mem[addr_i];
  end

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: arbitrates trigger requests, steps through ROM-defined effects
// on a prescaled tick, and drives the external sound generator's control registers.
module sfx_sequencer
  import sfx_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned NUM_FX   = NumFx
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_FX-1:0] req,
  output logic [LfoW-1:0]   lfo_freq,
  output logic [NoiseW-1:0] noise_freq,
  output logic [VcoW-1:0]   vco1_freq,
  output logic [VcoW-1:0]   vco2_freq,
  output logic              vco1_select,
  output logic              vco2_select,
  output logic              noise_select,
  output logic [ShiftW-1:0] lfo_shift,
  output logic [MixW-1:0]   mixer,
  output logic              busy,
  output logic [IdW-1:0]    active_id,
  output logic              done
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  state_e state_q, state_d;

  logic [NUM_FX-1:0]  pending_q, pending_d, grant_mask;
  logic [IdW-1:0]     active_id_q, hi_id;
  logic               hi_valid, grant;
  logic [StepW-1:0]   step_q;
  logic [TickW-1:0]   tick_q;
  logic [DurCntW-1:0] dur_q;
  logic               last_q;
  logic               tick_wrap, expire, last_step;
  logic               apply, advance, finish;
  logic               done_q;

  logic [LfoW-1:0]    lfo_q;
  logic [NoiseW-1:0]  noise_q;
  logic [VcoW-1:0]    vco1_q, vco2_q;
  logic               vco1_sel_q, vco2_sel_q, noise_sel_q;
  logic [ShiftW-1:0]  shift_q;
  logic [MixW-1:0]    mixer_q;

  logic [RomW-1:0]    rom_data;
  sfx_word_t          word;

  sfx_rom u_rom (
    .clk_i  (clk),
    .addr_i ({active_id_q, step_q}),
    .data_o (rom_data)
  );

  assign word = sfx_word_t'(rom_data);

  // Highest pending index wins; while an effect runs only equal or higher indices preempt it
  always_comb begin
    hi_valid   = 1'b0;
    hi_id      = '0;
    grant_mask = '0;
    for (int i = 0; i < NUM_FX; i++) begin
      if (pending_q[i]) begin
        hi_valid = 1'b1;
        hi_id    = IdW'(i);
      end
    end
    grant = hi_valid && ((state_q == StIdle) || (hi_id >= active_id_q));
    if (grant) grant_mask[hi_id] = 1'b1;
    // A request arriving on the grant edge survives the clear
    pending_d = (pending_q & ~grant_mask) | req;
  end

  assign tick_wrap = (tick_q == TickLast);
  assign expire    = (state_q == StPlay) && tick_wrap && (dur_q == DurCntW'(1));
  assign last_step = last_q || (step_q == '1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (grant) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StLoad:  state_d = StApply;
        StApply: state_d = StPlay;
        StPlay:  if (expire) state_d = last_step ? StIdle : StLoad;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != StIdle);
    apply   = (state_q == StApply) && !grant;
    advance = expire && !grant && !last_step;
    finish  = expire && !grant && last_step;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      active_id_q <= '0;
      step_q      <= '0;
      tick_q      <= '0;
      dur_q       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      lfo_q       <= '0;
      noise_q     <= '0;
      vco1_q      <= '0;
      vco2_q      <= '0;
      vco1_sel_q  <= 1'b0;
      vco2_sel_q  <= 1'b0;
      noise_sel_q <= 1'b0;
      shift_q     <= '0;
      mixer_q     <= '0;
    end else begin
      pending_q <= pending_d;
      done_q    <= finish;

      if (grant) begin
        active_id_q <= hi_id;
        step_q      <= '0;
      end else if (advance) begin
        step_q <= step_q + StepW'(1);
      end

      if (apply) begin
        tick_q      <= '0;
        dur_q       <= (word.dur == '0) ? DurCntW'(1 << DurW) : {1'b0, word.dur};
        last_q      <= word.last;
        lfo_q       <= word.lfo;
        noise_q     <= word.noise;
        vco1_q      <= word.vco1;
        vco2_q      <= word.vco2;
        vco1_sel_q  <= word.vco1_sel;
        vco2_sel_q  <= word.vco2_sel;
        noise_sel_q <= word.noise_sel;
        shift_q     <= word.lfo_shift;
        mixer_q     <= word.mixer;
      end else if (state_q == StPlay) begin
        tick_q <= tick_wrap ? '0 : tick_q + TickW'(1);
        if (tick_wrap) dur_q <= dur_q - DurCntW'(1);
        // Silence on completion; the other controls keep their last values
        if (finish) mixer_q <= '0;
      end
    end
  end

  assign lfo_freq     = lfo_q;
  assign noise_freq   = noise_q;
  assign vco1_freq    = vco1_q;
  assign vco2_freq    = vco2_q;
  assign vco1_select  = vco1_sel_q;
  assign vco2_select  = vco2_sel_q;
  assign noise_select = noise_sel_q;
  assign lfo_shift    = shift_q;
  assign mixer        = mixer_q;
  assign active_id    = active_id_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer with TICK_DIV=4: expected step/done events are queued
// with their cycle stamps when requests are driven, and a negedge monitor pops and compares them.
module tb_sfx_sequencer;

  localparam int unsigned TickDiv = 4;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  req     = '0;
  logic [9:0]  lfo_freq;
  logic [11:0] noise_freq, vco1_freq, vco2_freq;
  logic        vco1_select, vco2_select, noise_select;
  logic [2:0]  lfo_shift;
  logic [3:0]  mixer;
  logic        busy, done;
  logic [1:0]  active_id;
  logic [55:0] outv;

  sfx_sequencer #(
    .TICK_DIV (TickDiv),
    .NUM_FX   (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .lfo_freq     (lfo_freq),
    .noise_freq   (noise_freq),
    .vco1_freq    (vco1_freq),
    .vco2_freq    (vco2_freq),
    .vco1_select  (vco1_select),
    .vco2_select  (vco2_select),
    .noise_select (noise_select),
    .lfo_shift    (lfo_shift),
    .mixer        (mixer),
    .busy         (busy),
    .active_id    (active_id),
    .done         (done)
  );

  assign outv = {lfo_freq, noise_freq, vco1_freq, vco2_freq,
                 vco1_select, vco2_select, noise_select, lfo_shift, mixer};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_done;
    logic [1:0]  id;
    logic [55:0] vec;
    int          stamp;
  } ev_t;

  typedef struct packed {
    logic [3:0] req;
    logic [1:0] id;
    logic       two_steps;
    int         t_step1;
    int         t_done;
  } vec_t;

  ev_t  exp_q[$];
  vec_t tbl[3];

  // Expected generator outputs for each effect step, independent of the RTL package
  function automatic logic [55:0] fx_vec(input int id, input int step);
    logic [2:0]  k;
    logic [9:0]  lfo;
    logic [11:0] nz, v1, v2;
    logic        s1, s2, sn;
    logic [2:0]  sh;
    logic [3:0]  mx;
    k = 3'(step);
    lfo = '0; nz = '0; v1 = '0; v2 = '0; s1 = 0; s2 = 0; sn = 0; sh = '0; mx = '0;
    case (id)
      0: begin
        lfo = 10'h011; nz = 12'h101; v1 = 12'h201; v2 = 12'h301;
        s1 = 1; s2 = 0; sn = 1; sh = 3'd1; mx = 4'h9;
      end
      1: begin
        if (step == 0) begin
          lfo = 10'h021; nz = 12'h111; v1 = 12'h211; v2 = 12'h311;
          s1 = 0; s2 = 1; sn = 0; sh = 3'd2; mx = 4'hA;
        end else begin
          lfo = 10'h022; nz = 12'h112; v1 = 12'h212; v2 = 12'h312;
          s1 = 1; s2 = 1; sn = 0; sh = 3'd3; mx = 4'hB;
        end
      end
      2: begin
        if (step == 0) begin
          lfo = 10'h031; nz = 12'h121; v1 = 12'h221; v2 = 12'h321;
          s1 = 0; s2 = 0; sn = 1; sh = 3'd4; mx = 4'hC;
        end else begin
          lfo = 10'h032; nz = 12'h122; v1 = 12'h222; v2 = 12'h322;
          s1 = 1; s2 = 0; sn = 0; sh = 3'd5; mx = 4'hD;
        end
      end
      default: begin
        lfo = 10'h041 + 10'(k); nz = 12'h131 + 12'(k);
        v1 = 12'h231 + 12'(k); v2 = 12'h331 + 12'(k);
        s1 = k[0]; s2 = k[1]; sn = k[2]; sh = k; mx = 4'(k) + 4'd1;
      end
    endcase
    return {lfo, nz, v1, v2, s1, s2, sn, sh, mx};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic push_step(input int id, input int step, input int stamp);
    ev_t e;
    e.is_done = 1'b0;
    e.id      = 2'(id);
    e.vec     = fx_vec(id, step);
    e.stamp   = stamp;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int id, input int step, input int stamp);
    ev_t         e;
    logic [55:0] v;
    v         = fx_vec(id, step);
    e.is_done = 1'b1;
    e.id      = 2'(id);
    e.vec     = {v[55:4], 4'h0};
    e.stamp   = stamp;
    exp_q.push_back(e);
  endtask

  // Monitor: a done pulse or any change of the generator controls is one event
  initial begin
    logic [55:0] prev;
    ev_t         e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = outv;
      end else begin
        if (done || (outv != prev)) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got done=%0b id=%0d vec=%h cyc=%0d, required none",
                     done, active_id, outv, cyc);
          end else begin
            e = exp_q.pop_front();
            if (done !== e.is_done || active_id !== e.id || outv !== e.vec || cyc != e.stamp) begin
              failures++;
              $display("FAIL event: got done=%0b id=%0d vec=%h cyc=%0d, required done=%0b id=%0d vec=%h cyc=%0d",
                       done, active_id, outv, cyc, e.is_done, e.id, e.vec, e.stamp);
            end
          end
        end
        prev = outv;
      end
    end
  end

  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-clock request pulse; sampled on the next rising edge
  task automatic pulse(input logic [3:0] pat);
    req = pat;
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    exp_q.delete();
    req     = '0;
    reset_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_active_id", 64'(active_id), 64'd0);
    check("rst_outputs", 64'(outv), 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected events outstanding after %0d cycles, required 0",
               exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int base;
    int nbusy;

    // {req, winning id, has step 1, stamp of step 1, stamp of done} relative to the req edge
    tbl[0] = '{req: 4'b0001, id: 2'd0, two_steps: 1'b0, t_step1: 0,  t_done: 15};
    tbl[1] = '{req: 4'b0010, id: 2'd1, two_steps: 1'b1, t_step1: 13, t_done: 17};
    tbl[2] = '{req: 4'b0100, id: 2'd2, two_steps: 1'b1, t_step1: 25, t_done: 33};

    #1 reset_n = 1'b0;

    for (int v = 0; v < 3; v++) begin
      do_reset();
      base = cyc + 1;
      push_step(int'(tbl[v].id), 0, base + 3);
      if (tbl[v].two_steps) push_step(int'(tbl[v].id), 1, base + tbl[v].t_step1);
      push_done(int'(tbl[v].id), tbl[v].two_steps ? 1 : 0, base + tbl[v].t_done);
      pulse(tbl[v].req);
      nbusy = 0;
      for (int c = 0; c <= tbl[v].t_done + 4; c++) begin
        @(negedge clk);
        if (busy) nbusy++;
      end
      check("busy_cycles", 64'(nbusy), 64'(tbl[v].t_done - 1));
      wait_drain(50);
    end

    // Simultaneous requests: effect 1 first, effect 0 right after its done
    do_reset();
    base = cyc + 1;
    push_step(1, 0, base + 3);
    push_step(1, 1, base + 13);
    push_done(1, 1, base + 17);
    push_step(0, 0, base + 20);
    push_done(0, 0, base + 32);
    pulse(4'b0011);
    wait_drain(60);

    // Preempt effect 1 in step 1, queue a lower request, then restart effect 2 from step 1
    do_reset();
    base = cyc + 1;
    push_step(1, 0, base + 3);
    push_step(1, 1, base + 13);
    push_step(2, 0, base + 17);
    push_step(2, 1, base + 39);
    push_step(2, 0, base + 44);
    push_step(2, 1, base + 66);
    push_done(2, 1, base + 74);
    push_step(0, 0, base + 77);
    push_done(0, 0, base + 89);
    pulse(4'b0010);
    goto_cyc(base + 13);
    pulse(4'b0100);
    goto_cyc(base + 19);
    pulse(4'b0001);
    goto_cyc(base + 40);
    pulse(4'b0100);
    wait_drain(100);

    // Request repeated on the grant edge keeps the pending bit and restarts the effect
    do_reset();
    base = cyc + 1;
    push_step(0, 0, base + 4);
    push_done(0, 0, base + 16);
    pulse(4'b0001);
    pulse(4'b0001);
    wait_drain(40);

    // dur=0 step lasts 256 ticks; eight non-last steps end after step 7
    do_reset();
    base = cyc + 1;
    push_step(3, 0, base + 3);
    for (int k = 1; k < 8; k++) push_step(3, k, base + 1029 + 6 * (k - 1));
    push_done(3, 7, base + 1069);
    pulse(4'b1000);
    wait_drain(1100);

    // Asynchronous reset in the middle of PLAY with another request pending
    do_reset();
    base = cyc + 1;
    push_step(2, 0, base + 3);
    pulse(4'b0100);
    goto_cyc(base + 9);
    pulse(4'b0001);
    goto_cyc(base + 12);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_mixer", 64'(mixer), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_outputs", 64'(outv), 64'd0);
    check("async_rst_events_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    nbusy = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    check("pending_cleared_by_reset", 64'(nbusy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
